// File: rtl/dot_product_pkg.sv
// Shared definitions for the streaming dot-product engine: width helpers
// and the controller state encodings.
package dot_product_pkg;

  // Ceiling log2, usable in parameter expressions (clog2(1) == 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Result width large enough for LANES*MAX_BEATS full-width products.
  function automatic int res_width(input int a_w, input int b_w,
                                   input int lanes, input int max_beats);
    return a_w + b_w + clog2(lanes * max_beats);
  endfunction

  // Controller states.
  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

endpackage

// File: rtl/dot_product_lane_tree.sv
// Stage 1: per-lane multipliers, registered with the beat's first/last tag.
// Stage 2: registered adder tree over the lane products.
module dot_product_lane_tree
  import dot_product_pkg::*;
#(
  parameter int  LANES        = 4,
  parameter int  A_DATA_WIDTH = 16,
  parameter int  B_DATA_WIDTH = 16,
  localparam int PROD_W       = A_DATA_WIDTH + B_DATA_WIDTH,
  localparam int SUM_W        = PROD_W + clog2(LANES)
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            beat_valid_i,
  input  logic                            beat_first_i,
  input  logic                            beat_last_i,
  input  logic                            signed_i,
  input  logic [A_DATA_WIDTH*LANES-1:0]   a_i,
  input  logic [B_DATA_WIDTH*LANES-1:0]   b_i,
  output logic                            sum_valid_o,
  output logic                            sum_first_o,
  output logic                            sum_last_o,
  output logic                            sum_signed_o,
  output logic [SUM_W-1:0]                sum_o
);

  logic [PROD_W-1:0] prod_d [LANES];
  logic [PROD_W-1:0] prod_q [LANES];
  logic              s1_valid_q, s1_first_q, s1_last_q, s1_signed_q;
  logic [SUM_W-1:0]  sum_d;
  logic [SUM_W-1:0]  sum_q;
  logic              s2_valid_q, s2_first_q, s2_last_q, s2_signed_q;

  // Lane products: operands extended to the full product width first, so the
  // low PROD_W bits of the multiply are exact in both signed and unsigned mode.
  always_comb begin : lane_mult
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    for (int i = 0; i < LANES; i++) begin
      if (signed_i) begin
        a_ext = PROD_W'($signed(a_i[i*A_DATA_WIDTH +: A_DATA_WIDTH]));
        b_ext = PROD_W'($signed(b_i[i*B_DATA_WIDTH +: B_DATA_WIDTH]));
      end else begin
        a_ext = PROD_W'(a_i[i*A_DATA_WIDTH +: A_DATA_WIDTH]);
        b_ext = PROD_W'(b_i[i*B_DATA_WIDTH +: B_DATA_WIDTH]);
      end
      prod_d[i] = a_ext * b_ext;
    end
  end

  // Adder tree over the registered products, extended per the beat's mode.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first; otherwise a missed path infers a latch.
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_signed_q) sum_d = sum_d + SUM_W'($signed(prod_q[i]));
      else             sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  // Stage 1 register: products captured only on an accepted beat.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: pipeline registers, including the product array, are reset so a
      // reset mid-vector leaves no stale partial sums behind.
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_signed_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      s1_valid_q <= beat_valid_i;
      if (beat_valid_i) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
        s1_first_q  <= beat_first_i;
        s1_last_q   <= beat_last_i;
        s1_signed_q <= signed_i;
      end
    end
  end

  // Stage 2 register: tree sum plus the tag travelling with it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_signed_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q       <= sum_d;
        s2_first_q  <= s1_first_q;
        s2_last_q   <= s1_last_q;
        s2_signed_q <= s1_signed_q;
      end
    end
  end

  assign sum_valid_o  = s2_valid_q;
  assign sum_first_o  = s2_first_q;
  assign sum_last_o   = s2_last_q;
  assign sum_signed_o = s2_signed_q;
  assign sum_o        = sum_q;

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot product: beats of LANES element pairs are multiplied and
// summed in dot_product_lane_tree, then accumulated here. The controller
// stops input after the last beat, waits for it to reach the accumulator,
// and holds the result until the consumer accepts it.
module dot_product_stream
  import dot_product_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int A_DATA_WIDTH = 16,
  parameter int B_DATA_WIDTH = 16,
  parameter int MAX_BEATS    = 16,
  parameter int RES_WIDTH    = res_width(A_DATA_WIDTH, B_DATA_WIDTH, LANES, MAX_BEATS)
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic                          InLast,
  input  logic                          SignedMode,
  input  logic [A_DATA_WIDTH*LANES-1:0] A,
  input  logic [B_DATA_WIDTH*LANES-1:0] B,
  output logic                          OutValid,
  input  logic                          OutReady,
  output logic [RES_WIDTH-1:0]          DotProduct,
  output logic                          OutErr
);

  localparam int SUM_W = A_DATA_WIDTH + B_DATA_WIDTH + clog2(LANES);
  localparam int CNT_W = clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic [1:0]           state_q, state_d;
  logic                 in_vec_q, in_vec_d;     // a vector is in progress
  logic                 signed_q, signed_d;     // mode latched on first beat
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 err_q, err_d;
  logic [RES_WIDTH-1:0] acc_q, acc_d;
  logic [RES_WIDTH-1:0] res_q, res_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_err_q, out_err_d;

  logic                 accept;
  logic                 first_beat;
  logic                 eff_signed;
  logic                 s2_valid, s2_first, s2_last, s2_signed;
  logic [SUM_W-1:0]     s2_sum;
  logic [RES_WIDTH-1:0] acc_sum;

  // Ready is suppressed while reset is held, independent of the reset state.
  assign InReady    = (state_q == ACCUM) && !Reset;
  assign accept     = InValid && InReady;
  assign first_beat = accept && !in_vec_q;
  // The first beat uses the live mode; later beats use the latched copy.
  assign eff_signed = first_beat ? SignedMode : signed_q;

  dot_product_lane_tree #(
    .LANES        (LANES),
    .A_DATA_WIDTH (A_DATA_WIDTH),
    .B_DATA_WIDTH (B_DATA_WIDTH)
  ) u_lane_tree (
    .Clock        (Clock),
    .Reset        (Reset),
    .beat_valid_i (accept),
    .beat_first_i (first_beat),
    .beat_last_i  (InLast),
    .signed_i     (eff_signed),
    .a_i          (A),
    .b_i          (B),
    .sum_valid_o  (s2_valid),
    .sum_first_o  (s2_first),
    .sum_last_o   (s2_last),
    .sum_signed_o (s2_signed),
    .sum_o        (s2_sum)
  );

  // Stage 3 candidate: extend the tree sum and restart or add (wraps mod 2^RES_WIDTH).
  always_comb begin
    acc_sum = s2_signed ? RES_WIDTH'($signed(s2_sum)) : RES_WIDTH'(s2_sum);
    if (!s2_first) acc_sum = acc_sum + acc_q;
  end

  // Next-state logic: beat counter, sticky error, accumulator and controller.
  always_comb begin
    state_d     = state_q;
    in_vec_d    = in_vec_q;
    signed_d    = signed_q;
    count_d     = count_q;
    err_d       = err_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;

    if (s2_valid) acc_d = acc_sum;

    if (accept) begin
      in_vec_d = !InLast;
      if (first_beat) begin
        count_d   = CNT_W'(1);
        err_d     = 1'b0;
        signed_d  = SignedMode;
        out_err_d = 1'b0;
      end else if (count_q == CNT_MAX) begin
        err_d = 1'b1;                 // counter saturates, error is sticky
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    case (state_q)
      ACCUM: begin
        if (accept && InLast) state_d = DRAIN;
      end
      DRAIN: begin
        if (s2_valid && s2_last) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          res_d       = acc_sum;
          out_err_d   = err_q;
        end
      end
      OUT: begin
        if (OutReady) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ACCUM;
      in_vec_q    <= 1'b0;
      signed_q    <= 1'b0;
      count_q     <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_vec_q    <= in_vec_d;
      signed_q    <= signed_d;
      count_q     <= count_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign OutValid   = out_valid_q;
  assign DotProduct = res_q;
  assign OutErr     = out_err_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench for dot_product_stream (LANES=4, 16x16-bit, MAX_BEATS=16).
module tb_dot_product_stream;

  localparam int LANES = 4;
  localparam int AW    = 16;
  localparam int BW    = 16;
  localparam int RW    = 38;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             InValid, InReady, InLast, SignedMode;
  logic [AW*LANES-1:0] A;
  logic [BW*LANES-1:0] B;
  logic             OutValid, OutReady, OutErr;
  logic [RW-1:0]    DotProduct;

  int n_checks = 0;
  int n_errors = 0;

  dot_product_stream dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .InValid    (InValid),
    .InReady    (InReady),
    .InLast     (InLast),
    .SignedMode (SignedMode),
    .A          (A),
    .B          (B),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .DotProduct (DotProduct),
    .OutErr     (OutErr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat (same value in every lane) and hold it until accepted.
  // Returns 1 ns after the accepting edge with InValid dropped.
  task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                           input logic last, input logic smode);
    int waited = 0;
    A = {LANES{a}};
    B = {LANES{b}};
    InLast = last;
    SignedMode = smode;
    InValid = 1'b1;
    @(negedge Clock);
    while (!InReady && waited < 50) begin
      waited++;
      @(negedge Clock);
    end
    if (!InReady) check("in_ready_timeout", InReady, 1'b1);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    InLast = 1'b0;
  endtask

  // Called right after the last beat is accepted: checks latency (OutValid
  // seen at the 3rd negedge, i.e. after edge E+2), result and error flag,
  // and, when OutReady is high, the handshake at E+3.
  task automatic wait_result(input string tag, input logic [63:0] exp_dp, input logic exp_err);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!OutValid && n < 40);
    check({tag, "_latency"}, 64'(n), 64'd3);
    check({tag, "_dp"}, 64'(DotProduct), exp_dp);
    check({tag, "_err"}, 64'(OutErr), 64'(exp_err));
    if (OutReady) begin
      @(posedge Clock);
      #1;
      check({tag, "_valid_drop"}, 64'(OutValid), 64'd0);
      check({tag, "_ready_back"}, 64'(InReady), 64'd1);
    end
  endtask

  initial begin
    Reset = 1'b1;
    InValid = 1'b0;
    InLast = 1'b0;
    SignedMode = 1'b0;
    A = '0;
    B = '0;
    OutReady = 1'b1;

    // Reset values.
    repeat (2) @(posedge Clock);
    #1;
    check("rst_in_ready", 64'(InReady), 64'd0);
    check("rst_out_valid", 64'(OutValid), 64'd0);
    check("rst_dp", 64'(DotProduct), 64'd0);
    check("rst_err", 64'(OutErr), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("ready_after_rst", 64'(InReady), 64'd1);
    @(posedge Clock);
    #1;

    // Single beat 8*8 on four lanes.
    send_beat(16'd8, 16'd8, 1'b1, 1'b0);
    wait_result("one_beat", 64'd256, 1'b0);

    // Two beats separated by a 3-cycle InValid gap.
    send_beat(16'd8, 16'd8, 1'b0, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    check("gap_no_valid", 64'(OutValid), 64'd0);
    send_beat(16'd8, 16'd8, 1'b1, 1'b0);
    wait_result("gap", 64'd512, 1'b0);

    // 0xFFFF * 2: unsigned, signed, and mode toggled on a second beat.
    send_beat(16'hFFFF, 16'h0002, 1'b1, 1'b0);
    wait_result("unsigned_ff", 64'd524280, 1'b0);
    send_beat(16'hFFFF, 16'h0002, 1'b1, 1'b1);
    wait_result("signed_ff", 64'h3F_FFFF_FFF8, 1'b0);
    send_beat(16'hFFFF, 16'h0002, 1'b0, 1'b0);
    send_beat(16'hFFFF, 16'h0002, 1'b1, 1'b1);
    wait_result("mode_held", 64'd1048560, 1'b0);

    // Full-length vector of maximal unsigned products: no wrap, no error.
    for (int i = 0; i < 15; i++) send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    wait_result("max_len", 64'd274869518400, 1'b0);

    // One beat too many: error reported, then cleared by the next vector.
    for (int i = 0; i < 16; i++) send_beat(16'd1, 16'd1, 1'b0, 1'b0);
    send_beat(16'd1, 16'd1, 1'b1, 1'b0);
    wait_result("overlong", 64'd68, 1'b1);
    send_beat(16'd1, 16'd1, 1'b1, 1'b0);
    wait_result("after_err", 64'd4, 1'b0);

    // Output backpressure for 5 cycles.
    OutReady = 1'b0;
    send_beat(16'd8, 16'd8, 1'b1, 1'b0);
    wait_result("bp", 64'd256, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      check("bp_hold_dp", 64'(DotProduct), 64'd256);
      check("bp_hold_valid", 64'(OutValid), 64'd1);
      check("bp_in_ready", 64'(InReady), 64'd0);
    end
    OutReady = 1'b1;
    @(posedge Clock);
    #1;
    check("bp_valid_drop", 64'(OutValid), 64'd0);
    check("bp_ready_back", 64'(InReady), 64'd1);

    // Reset in the middle of a vector discards the partial sum.
    send_beat(16'd100, 16'd100, 1'b0, 1'b0);
    send_beat(16'd100, 16'd100, 1'b0, 1'b0);
    Reset = 1'b1;
    #1;
    check("mid_rst_ready", 64'(InReady), 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    send_beat(16'd8, 16'd8, 1'b1, 1'b0);
    wait_result("after_rst", 64'd256, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
- Streaming, pipelined, parametrised successor to the fixed-DIM dotProduct.
- Vectors arrive as a sequence of beats, LANES element pairs per beat. Vector length is variable, up to MAX_BEATS beats, and ends at the InLast beat.
- Supports unsigned and signed (two's complement) operation.
- Feeds the matrix-multiply row/column engine through valid/ready handshakes on both sides.

Parameters:
- LANES, 4, element pairs per beat (>=1).
- A_DATA_WIDTH, 16, width of each A element.
- B_DATA_WIDTH, 16, width of each B element.
- MAX_BEATS, 16, maximum legal beats per vector (>=1).
- RES_WIDTH, A_DATA_WIDTH+B_DATA_WIDTH+clog2(LANES*MAX_BEATS), result width; default 38. Derived, do not override.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- InValid  in  1  beat valid.
- InReady  out  1  beat accept; a beat transfers at a rising edge with InValid&&InReady.
- InLast  in  1  final beat of the current vector.
- SignedMode  in  1  1 = signed elements; sampled on the first beat of a vector only.
- A  in  A_DATA_WIDTH*LANES  lane i = A[i*A_DATA_WIDTH +: A_DATA_WIDTH].
- B  in  B_DATA_WIDTH*LANES  same lane packing as A.
- OutValid  out  1  result valid.
- OutReady  in  1  result accept.
- DotProduct  out  RES_WIDTH  accumulated result.
- OutErr  out  1  vector exceeded MAX_BEATS beats; qualified by OutValid.

Behaviour:
- Reset (asynchronous, active-high): state=ACCUM and all pipeline registers cleared.
  - Output reset values: InReady=0 while Reset high, OutValid=0, DotProduct=0, OutErr=0.
  - InReady=1 in the first cycle after Reset deasserts.
  - Reset mid-vector discards all partial sums.
- Pipeline, where E = edge of the handshake that transfers a beat:
  - Stage 1 (E): register LANES products, each A_DATA_WIDTH+B_DATA_WIDTH wide, plus a first/last tag.
  - Stage 2 (E+1): register the adder-tree sum, widened by clog2(LANES).
  - Stage 3 (E+2): accumulator. It is loaded with the sum if the beat was first, otherwise acc += sum.
- Arithmetic:
  - Products, tree and accumulator are all RES_WIDTH-safe.
  - SignedMode=1: sign-extend operands and intermediate values; result is two's complement.
  - SignedMode=0: zero-extend.
  - The SignedMode latch is held for the whole vector; changes mid-vector are ignored.
  - Accumulation wraps modulo 2^RES_WIDTH; this occurs only in the overflow case below.
- FSM states:
  - ACCUM: InReady=1. A first beat clears the beat counter and latches SignedMode. An InLast handshake goes to DRAIN.
  - DRAIN: InReady=0. Waits until the last beat reaches stage 3; OutValid and DotProduct are registered at edge E+2, then go to OUT.
  - OUT: InReady=0, OutValid=1, DotProduct/OutErr held stable. On OutValid&&OutReady: OutValid=0 at that edge, go to ACCUM, InReady=1 the next cycle.
- Latency and throughput:
  - Latency: OutValid high from edge E+2 of the InLast beat. With OutReady already high, the result transfers at E+3.
  - Throughput per vector = beats + 3 cycles (minimum, with OutReady high).
- Beat counter:
  - Saturating, clog2(MAX_BEATS+1) bits.
  - An accepted beat with count already MAX_BEATS sets the sticky error for that vector; accumulation continues.
  - OutErr is reported with the result and cleared when the next vector starts.
- Other boundary cases:
  - Single-beat vector (first and last in the same beat) is legal.
  - InValid=0 gaps mid-vector are allowed and do not alter the accumulator.
  - Inputs are ignored while InReady=0.

Decomposition:
- Shared package dot_product_pkg holds:
  - a clog2 function (replaces the unusable CLOG2 macro);
  - the RES_WIDTH derivation;
  - FSM state localparams ACCUM/DRAIN/OUT.
- One sub-module, dot_product_lane_tree. It contains the stage-1 multipliers plus the stage-2 registered adder tree, with a signed-mode input. The top module holds the FSM, counter and accumulator.

Test Plan:
- Unsigned, 1 beat, all lanes A=8, B=8 (LANES=4), InLast=1 -> DotProduct=256, OutErr=0, OutValid at E+2.
- Unsigned, 2 beats of 8*8 with a 3-cycle InValid gap between them -> 512.
- A lanes=0xFFFF, B lanes=0x0002, 1 beat:
  - SignedMode=0 -> 524280;
  - SignedMode=1 -> -8 (0x3FFFFFFFF8);
  - SignedMode toggled on a 2nd beat -> mode of the first beat applies.
- 16 beats of all 0xFFFF*0xFFFF unsigned -> 274869518400, no wrap, OutErr=0.
- 17 beats of 1*1 -> DotProduct=68, OutErr=1; the next vector of 1 beat of 1*1 -> 4, OutErr=0.
- Backpressure and reset:
  - OutReady low 5 cycles after OutValid -> DotProduct held, InReady=0 throughout; InReady=1 the cycle after the handshake.
  - Reset pulse after 2 beats, then 1 beat of 8*8 -> 256.
